wm8731_i2c_target: RTL and testbench

Synthesizable I2C target that emulates the WM8731 control port, the responder for the codec configuration writes the FPGA issues. It decodes the codec's two-byte register-write format and ACKs/NACKs the bus like the real device. It maintains a shadow bank of codec registers with WM8731 reset defaults. It is used in loopback configuration tests and as a stand-in codec on boards without one.

---
 rtl/wm8731_pkg.sv | 41 ++++
 rtl/wm8731_i2c_target_line_cond.sv | 88 ++++++++
 rtl/wm8731_i2c_target.sv | 173 +++++++++++++++++
 tb/tb_wm8731_i2c_target.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared WM8731 control-port definitions: register map, reset defaults, FSM states.
// Used by both the target emulation and the initiator side.
package wm8731_pkg;

  localparam int unsigned NUM_REGS = 10;
  localparam int unsigned REG_W    = 9;

  typedef logic [REG_W-1:0] reg_data_t;
  typedef logic [6:0]       reg_addr_t;

  localparam reg_addr_t R_LINVOL = 7'h00;
  localparam reg_addr_t R_RINVOL = 7'h01;
  localparam reg_addr_t R_LOUT   = 7'h02;
  localparam reg_addr_t R_ROUT   = 7'h03;
  localparam reg_addr_t R_APANA  = 7'h04;
  localparam reg_addr_t R_DPATH  = 7'h05;
  localparam reg_addr_t R_PWR    = 7'h06;
  localparam reg_addr_t R_IFACE  = 7'h07;
  localparam reg_addr_t R_SRATE  = 7'h08;
  localparam reg_addr_t R_ACTIVE = 7'h09;
  localparam reg_addr_t R_RESET  = 7'h0F;

  localparam reg_data_t REG_DEFAULTS [NUM_REGS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_EXTRA,
    ST_NACK,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/wm8731_i2c_target_line_cond.sv
// I2C line conditioning: SCL/SDA synchronizers, optional glitch filter
// (I2C_GLITCH_FILTER_EN), and edge / START / STOP detection.
module i2c_line_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_c,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  // Bit 1 carries SDA, bit 0 carries SCL.
  logic [1:0] line_s, line_f, prev_q, prev_d, rise, fall;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    line_s     = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};
    prev_d     = line_f;
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    flt_q, flt_d;

  // A line value is accepted only after it differs for FILT_LEN consecutive cycles.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (line_s[i] != flt_q[i]) begin
        if (cnt_q[i] >= CW'(FILT_LEN - 1)) begin
          flt_d[i] = line_s[i];
        end else begin
          cnt_d[i] = CW'(cnt_q[i] + CW'(1));
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      flt_q    <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      flt_q    <= flt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign line_f = flt_q;
`else
  assign line_f = line_s;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      prev_q     <= 2'b11;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      prev_q     <= prev_d;
    end
  end

  assign rise         = line_f & ~prev_q;
  assign fall         = ~line_f & prev_q;
  assign o_sda_c      = line_f[1];
  assign o_scl_rise_c = rise[0];
  assign o_scl_fall_c = fall[0];
  assign o_start_c    = fall[1] & line_f[0] & prev_q[0];
  assign o_stop_c     = rise[1] & line_f[0] & prev_q[0];

endmodule

// File: rtl/wm8731_i2c_target.sv
// WM8731 control-port I2C target: decodes two-byte register writes into a shadow bank.
// Optional SCL/SDA glitch filter is enabled with I2C_GLITCH_FILTER_EN.
module wm8731_i2c_target
  import wm8731_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_i2c_scl,
  inout  wire        io_i2c_sda,
  output logic       o_busy,
  output logic       o_wr_stb,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_line_cond (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_scl        (i_i2c_scl),
    .i_sda        (io_i2c_sda),
    .o_sda_c      (sda_s),
    .o_scl_rise_c (scl_rise),
    .o_scl_fall_c (scl_fall),
    .o_start_c    (start_det),
    .o_stop_c     (stop_det)
  );

  state_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d, b1_q, b1_d;
  logic      sda_oe_q, sda_oe_d, busy_q, busy_d, wr_stb_q, wr_stb_d;
  reg_addr_t wr_addr_q, wr_addr_d, cmt_addr;
  reg_data_t wr_data_q, wr_data_d, cmt_data;
  reg_data_t bank_q [NUM_REGS];
  reg_data_t bank_d [NUM_REGS];

  assign cmt_addr = b1_q[7:1];
  assign cmt_data = {b1_q[0], shreg_q};

  // Byte framing, ACK/NACK drive and write commit; START/STOP preempt everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    b1_d      = b1_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_d    = bank_q;
    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      if (scl_rise && (cnt_q < 4'd8) &&
          (state_q inside {ST_ADDR, ST_BYTE1, ST_BYTE2, ST_EXTRA})) begin
        shreg_d = {shreg_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
      end
      if (scl_fall) begin
        unique case (state_q)
          ST_ADDR: if (cnt_q == 4'd8) begin
            cnt_d = '0;
            if (shreg_q == {DEV_ADDR, 1'b0}) begin
              state_d  = ST_ACK_A;
              sda_oe_d = 1'b1;
            end else if (shreg_q[7:1] == DEV_ADDR) begin
              state_d = ST_NACK;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
          ST_BYTE1: if (cnt_q == 4'd8) begin
            cnt_d    = '0;
            b1_d     = shreg_q;
            state_d  = ST_ACK_1;
            sda_oe_d = 1'b1;
          end
          ST_BYTE2: if (cnt_q == 4'd8) begin
            cnt_d     = '0;
            state_d   = ST_ACK_2;
            sda_oe_d  = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = cmt_addr;
            wr_data_d = cmt_data;
            if (cmt_addr < 7'(NUM_REGS)) begin
              bank_d[cmt_addr[3:0]] = cmt_data;
            end else if (cmt_addr == R_RESET) begin
              bank_d = REG_DEFAULTS;
            end
          end
          ST_EXTRA: if (cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = ST_NACK;
          end
          ST_ACK_A: begin
            state_d  = ST_BYTE1;
            sda_oe_d = 1'b0;
          end
          ST_ACK_1: begin
            state_d  = ST_BYTE2;
            sda_oe_d = 1'b0;
          end
          ST_ACK_2: begin
            state_d  = ST_EXTRA;
            sda_oe_d = 1'b0;
          end
          ST_NACK: state_d = ST_WAIT_STOP;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      b1_q      <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      bank_q    <= REG_DEFAULTS;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      b1_q      <= b1_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      bank_q    <= bank_d;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_addr < 4'(NUM_REGS)) begin
      o_rd_data = bank_q[i_rd_addr];
    end
  end

  assign io_i2c_sda = sda_oe_q ? 1'b0 : 1'bz;
  assign o_busy     = busy_q;
  assign o_wr_stb   = wr_stb_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// Directed self-checking bench for wm8731_i2c_target acting as an I2C initiator.
module tb_wm8731_i2c_target;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl = 1'b1;
  logic       sda_oe = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  wire        sda_bus;
  logic       busy, wr_stb;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;

  int         checks = 0;
  int         errors = 0;
  int         stb_cnt = 0;
  logic [6:0] cap_addr = 7'd0;
  logic [8:0] cap_data = 9'd0;
  logic       dut_low = 1'b0;
  logic [8:0] exp_def [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                               9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

  assign sda_bus = sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  wm8731_i2c_target dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_i2c_scl  (scl),
    .io_i2c_sda (sda_bus),
    .o_busy     (busy),
    .o_wr_stb   (wr_stb),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    if (sda_bus === 1'b0 && !sda_oe) dut_low = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_oe = 1'b0; #(Q); scl = 1'b1; #(Q); sda_oe = 1'b1; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_oe = 1'b1; #(Q); scl = 1'b1; #(Q); sda_oe = 1'b0; #(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
    for (int i = 7; i > 7 - n; i--) begin
      sda_oe = ~b[i];
      if (glitch && i == 4) begin
        #(Q/2); scl = 1'b1; #10; scl = 1'b0; #(Q/2 - 10);
      end else begin
        #(Q);
      end
      scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    end
  endtask

  task automatic get_ack(output logic ack);
    sda_oe = 1'b0; #(Q); scl = 1'b1; #(Q); ack = sda_bus; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic xfer3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input bit glitch, output logic [2:0] acks);
    logic a0, a1, a2;
    i2c_start();
    send_bits(b0, 8, 1'b0); get_ack(a0);
    send_bits(b1, 8, 1'b0); get_ack(a1);
    send_bits(b2, 8, glitch); get_ack(a2);
    i2c_stop();
    acks = {a0, a1, a2};
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    #(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wr_stb); end
    checks++; if (wr_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", wr_addr); end
    checks++; if (wr_data !== 9'h000) begin errors++; $display("FAIL reset_data: got %h want 000", wr_data); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      exp = (i < 10) ? exp_def[i] : 9'h000;
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL reset_bank[%0d]: got %h want %h", i, rd_data, exp); end
    end
    rstn = 1'b1; #(Q);
  endtask

  task automatic test_write_r4();
    logic a0, a1, a2;
    int s0;
    s0 = stb_cnt;
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL w4_busy_start: got %b want 1", busy); end
    send_bits(8'h34, 8, 1'b0); get_ack(a0);
    send_bits(8'h08, 8, 1'b0); get_ack(a1);
    send_bits(8'h12, 8, 1'b0); get_ack(a2);
    i2c_stop();
    rd_addr = 4'd4; #1;
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL w4_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (stb_cnt - s0 != 1) begin errors++; $display("FAIL w4_strobes: got %0d want 1", stb_cnt - s0); end
    checks++; if (cap_addr !== 7'h04) begin errors++; $display("FAIL w4_addr: got %h want 04", cap_addr); end
    checks++; if (cap_data !== 9'h012) begin errors++; $display("FAIL w4_data: got %h want 012", cap_data); end
    checks++; if (rd_data !== 9'h012) begin errors++; $display("FAIL w4_bank: got %h want 012", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w4_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_reg_reset();
    logic [2:0] acks;
    int s0;
    s0 = stb_cnt;
    xfer3(8'h34, 8'h01, 8'h17, 1'b0, acks);
    rd_addr = 4'd0; #1;
    checks++; if (rd_data !== 9'h117) begin errors++; $display("FAIL r0_bank: got %h want 117", rd_data); end
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL r0_acks: got %b want 000", acks); end
    xfer3(8'h34, 8'h1E, 8'h00, 1'b0, acks);
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL r15_acks: got %b want 000", acks); end
    checks++; if (rd_data !== 9'h097) begin errors++; $display("FAIL r15_r0: got %h want 097", rd_data); end
    rd_addr = 4'd4; #1;
    checks++; if (rd_data !== 9'h00A) begin errors++; $display("FAIL r15_r4: got %h want 00A", rd_data); end
    checks++; if (stb_cnt - s0 != 2) begin errors++; $display("FAIL r15_strobes: got %0d want 2", stb_cnt - s0); end
    checks++; if (cap_addr !== 7'h0F) begin errors++; $display("FAIL r15_addr: got %h want 0F", cap_addr); end
  endtask

  task automatic test_reset_mid();
    i2c_start();
    send_bits(8'h34, 8, 1'b0);
    sda_oe = 1'b0; #(Q); scl = 1'b1; #(Q);
    checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %b want 0", sda_bus); end
    rstn = 1'b0; #1;
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rmid_sda: got %b want 1", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    scl = 1'b0; #(Q); rstn = 1'b1; #(Q);
  endtask

  task automatic test_bad_addr();
    logic a;
    int s0;
    s0 = stb_cnt; dut_low = 1'b0;
    i2c_start();
    send_bits(8'h36, 8, 1'b0); get_ack(a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bad_ack: got %b want 1", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_busy: got %b want 1", busy); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy_stop: got %b want 0", busy); end
    checks++; if (stb_cnt != s0) begin errors++; $display("FAIL bad_strobes: got %0d want 0", stb_cnt - s0); end
    checks++; if (dut_low !== 1'b0) begin errors++; $display("FAIL bad_drive: got %b want 0", dut_low); end
  endtask

  task automatic test_read_attempt();
    logic a0, a1;
    int s0;
    s0 = stb_cnt; dut_low = 1'b0;
    i2c_start();
    send_bits(8'h35, 8, 1'b0); get_ack(a0);
    send_bits(8'h08, 8, 1'b0); get_ack(a1);
    i2c_stop();
    rd_addr = 4'd4; #1;
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL rd_acks: got %b want 11", {a0, a1}); end
    checks++; if (dut_low !== 1'b0) begin errors++; $display("FAIL rd_drive: got %b want 0", dut_low); end
    checks++; if (rd_data !== 9'h00A) begin errors++; $display("FAIL rd_bank: got %h want 00A", rd_data); end
    checks++; if (stb_cnt != s0) begin errors++; $display("FAIL rd_strobes: got %0d want 0", stb_cnt - s0); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    logic [2:0] acks;
    int s0;
    s0 = stb_cnt;
    i2c_start();
    send_bits(8'h34, 8, 1'b0); get_ack(a0);
    send_bits(8'h0C, 8, 1'b0); get_ack(a1);
    send_bits(8'h00, 5, 1'b0);
    i2c_stop();
    rd_addr = 4'd6; #1;
    checks++; if (stb_cnt != s0) begin errors++; $display("FAIL abort_strobes: got %0d want 0", stb_cnt - s0); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL abort_sda: got %b want 1", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (rd_data !== 9'h09F) begin errors++; $display("FAIL abort_bank: got %h want 09F", rd_data); end
    xfer3(8'h34, 8'h0C, 8'h00, 1'b0, acks);
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL abort_next_acks: got %b want 000", acks); end
    checks++; if (rd_data !== 9'h000) begin errors++; $display("FAIL abort_next_bank: got %h want 000", rd_data); end
    checks++; if (stb_cnt - s0 != 1) begin errors++; $display("FAIL abort_next_strobes: got %0d want 1", stb_cnt - s0); end
  endtask

  task automatic test_extra_byte();
    logic a0, a1, a2, a3;
    int s0;
    s0 = stb_cnt;
    i2c_start();
    send_bits(8'h34, 8, 1'b0); get_ack(a0);
    send_bits(8'h0E, 8, 1'b0); get_ack(a1);
    send_bits(8'h42, 8, 1'b0); get_ack(a2);
    send_bits(8'hAA, 8, 1'b0); get_ack(a3);
    i2c_stop();
    rd_addr = 4'd7; #1;
    checks++; if ({a0, a1, a2, a3} !== 4'b0001) begin errors++; $display("FAIL extra_acks: got %b want 0001", {a0, a1, a2, a3}); end
    checks++; if (stb_cnt - s0 != 1) begin errors++; $display("FAIL extra_strobes: got %0d want 1", stb_cnt - s0); end
    checks++; if (rd_data !== 9'h042) begin errors++; $display("FAIL extra_bank: got %h want 042", rd_data); end
    checks++; if (cap_data !== 9'h042) begin errors++; $display("FAIL extra_data: got %h want 042", cap_data); end
  endtask

  task automatic test_back_to_back();
    logic a [9];
    int s0;
    s0 = stb_cnt;
    i2c_start();
    send_bits(8'h34, 8, 1'b0); get_ack(a[0]);
    send_bits(8'h10, 8, 1'b0); get_ack(a[1]);
    send_bits(8'h55, 8, 1'b0); get_ack(a[2]);
    i2c_start();
    send_bits(8'h34, 8, 1'b0); get_ack(a[3]);
    send_bits(8'h12, 8, 1'b0); get_ack(a[4]);
    send_bits(8'h01, 8, 1'b0); get_ack(a[5]);
    i2c_start();
    send_bits(8'h34, 8, 1'b0); get_ack(a[6]);
    send_bits(8'h20, 8, 1'b0); get_ack(a[7]);
    send_bits(8'h33, 8, 1'b0); get_ack(a[8]);
    i2c_stop();
    for (int i = 0; i < 9; i++) begin
      checks++; if (a[i] !== 1'b0) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want 0", i, a[i]); end
    end
    checks++; if (stb_cnt - s0 != 3) begin errors++; $display("FAIL b2b_strobes: got %0d want 3", stb_cnt - s0); end
    checks++; if (cap_addr !== 7'h10) begin errors++; $display("FAIL b2b_addr: got %h want 10", cap_addr); end
    checks++; if (cap_data !== 9'h033) begin errors++; $display("FAIL b2b_data: got %h want 033", cap_data); end
    rd_addr = 4'd8; #1;
    checks++; if (rd_data !== 9'h055) begin errors++; $display("FAIL b2b_r8: got %h want 055", rd_data); end
    rd_addr = 4'd9; #1;
    checks++; if (rd_data !== 9'h001) begin errors++; $display("FAIL b2b_r9: got %h want 001", rd_data); end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [2:0] acks;
    int s0;
    s0 = stb_cnt;
    xfer3(8'h34, 8'h0A, 8'h06, 1'b1, acks);
    rd_addr = 4'd5; #1;
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL glitch_acks: got %b want 000", acks); end
    checks++; if (rd_data !== 9'h006) begin errors++; $display("FAIL glitch_bank: got %h want 006", rd_data); end
    checks++; if (stb_cnt - s0 != 1) begin errors++; $display("FAIL glitch_strobes: got %0d want 1", stb_cnt - s0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_r4();
    test_reg_reset();
    test_reset_mid();
    test_bad_addr();
    test_read_attempt();
    test_abort();
    test_extra_byte();
    test_back_to_back();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
